karatsuba_product_reducer: RTL and testbench



---
 rtl/karatsuba_pkg.sv | 24 ++
 rtl/poly_negacyclic_fold.sv | 27 ++
 rtl/karatsuba_product_reducer.sv | 114 +++++++++++
 tb/tb_karatsuba_product_reducer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// rtl/karatsuba_pkg.sv - shared state encoding and width helpers for the Karatsuba product path
//
// Contents:
//   state_t     : reducer FSM encoding (IDLE, FOLD, EMIT)
//   prod_width  : width of a (2D-1)-coefficient product word, (2D-1)*N bits
//   idx_width   : width of a coefficient index, clog2(D) bits (never below 1)

package karatsuba_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    EMIT = 2'd2
  } state_t;

  function automatic int prod_width(input int n, input int d);
    return (2 * d - 1) * n;
  endfunction

  function automatic int idx_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/poly_negacyclic_fold.sv
// rtl/poly_negacyclic_fold.sv - combinational negacyclic fold of a product into Z_(2^N)[x]/(x^D+1)
//
// Ports:
//   p : (2D-1)*N product word, coefficient k at bits [(k+1)*N-1 : k*N]
//   c : D*N reduced word, same packing
//
// Since x^D = -1, every term p_(i+D) x^(i+D) folds back as -p_(i+D) x^i.
// The product has no degree 2D-1 term, so the top coefficient passes through.

module poly_negacyclic_fold
  import karatsuba_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 4
) (
  input  logic [prod_width(N, D)-1:0] p,
  output logic [D*N-1:0]              c
);

  // Plain N-bit subtract: wraps mod 2^N, no saturation.
  for (genvar i = 0; i < D - 1; i++) begin : g_sub
    assign c[i*N +: N] = p[i*N +: N] - p[(i+D)*N +: N];
  end

  assign c[(D-1)*N +: N] = p[(D-1)*N +: N];

endmodule

// File: rtl/karatsuba_product_reducer.sv
// rtl/karatsuba_product_reducer.sv - folds a Karatsuba product negacyclically and streams D coefficients
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   in_valid   : in_p holds a product this cycle
//   in_ready   : block is idle and will accept a product
//   in_p       : (2D-1)*N product word, coefficient k at bits [(k+1)*N-1 : k*N]
//   out_valid  : out_coef/out_idx/out_last are valid
//   out_ready  : consumer takes the current coefficient
//   out_coef   : reduced coefficient
//   out_idx    : index of out_coef, 0 first
//   out_last   : high with out_idx = D-1
//
// Every output is decoded purely from flops (state, index, result), so there
// is no combinational path from in_valid or out_ready, and an asynchronous
// reset pulls the outputs to their idle values immediately.

module karatsuba_product_reducer
  import karatsuba_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [prod_width(N, D)-1:0]   in_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0]                  out_coef,
  output logic [idx_width(D)-1:0]       out_idx,
  output logic                          out_last
);

  localparam int             PW       = prod_width(N, D);
  localparam int             IW       = idx_width(D);
  localparam logic [IW-1:0]  IDX_LAST = IW'(D - 1);

  state_t          state_q, state_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [PW-1:0]   prod_q;
  logic [D*N-1:0]  result_q;
  logic [D*N-1:0]  fold_c;
  logic            capture;
  logic            fold_en;

  poly_negacyclic_fold #(
    .N (N),
    .D (D)
  ) u_fold (
    .p (prod_q),
    .c (fold_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      if (capture) begin
        prod_q <= in_p;
      end
      if (fold_en) begin
        result_q <= fold_c;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    capture = 1'b0;
    fold_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_n = FOLD;
        end
      end
      FOLD: begin
        fold_en = 1'b1;
        idx_n   = '0;
        state_n = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == IDX_LAST);
  assign out_coef  = out_valid ? result_q[int'(idx_q)*N +: N] : '0;

endmodule

// File: tb/tb_karatsuba_product_reducer.sv
// tb/tb_karatsuba_product_reducer.sv - directed vector bench for karatsuba_product_reducer (N=4, D=4)

module tb_karatsuba_product_reducer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int PW = (2 * D - 1) * N;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [PW-1:0]  in_p;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_coef;
  logic [IW-1:0]  out_idx;
  logic           out_last;

  karatsuba_product_reducer #(
    .N (N),
    .D (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // p6..p0 packed MS first; c3..c0 packed MS first.
  typedef struct {
    logic [PW-1:0]  p;
    logic [D*N-1:0] c;
  } vec_t;

  vec_t tbl[4];

  // Monitor: samples mid-cycle, records accepts/handshakes on the upcoming edge.
  int          cyc = 0;
  int          acc_edge[$];
  int          hs_edge[$];
  int          hs_coef[$];
  int          hs_idx[$];
  int          hs_last[$];
  logic        prev_stall = 1'b0;
  logic [N-1:0]  prev_coef;
  logic [IW-1:0] prev_idx;
  logic        prev_last;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_coef", int'(out_coef), int'(prev_coef));
        chk("hold_idx", int'(out_idx), int'(prev_idx));
        chk("hold_last", int'(out_last), int'(prev_last));
      end
      if (in_valid && in_ready) acc_edge.push_back(cyc + 1);
      if (out_valid && out_ready) begin
        hs_edge.push_back(cyc + 1);
        hs_coef.push_back(int'(out_coef));
        hs_idx.push_back(int'(out_idx));
        hs_last.push_back(int'(out_last));
      end
      prev_stall = out_valid && !out_ready;
      prev_coef  = out_coef;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end
  end

  task automatic clear_q();
    acc_edge.delete();
    hs_edge.delete();
    hs_coef.delete();
    hs_idx.delete();
    hs_last.delete();
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_edge.size() < n && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_count", acc_edge.size(), n);
  endtask

  task automatic wait_hs(input int n);
    int t = 0;
    while (hs_coef.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("handshake_count", hs_coef.size(), n);
  endtask

  // Compare recorded handshakes [base, base+D) against a packed expected word.
  task automatic chk_stream(input int base, input logic [D*N-1:0] c);
    logic [D*N-1:0] cv;
    cv = c;
    for (int k = 0; k < D; k++) begin
      if (base + k < hs_coef.size()) begin
        chk($sformatf("coef[%0d]", base + k), hs_coef[base+k], int'(cv[k*N +: N]));
        chk($sformatf("idx[%0d]", base + k), hs_idx[base+k], k);
        chk($sformatf("last[%0d]", base + k), hs_last[base+k], (k == D - 1) ? 1 : 0);
      end else begin
        chk($sformatf("missing[%0d]", base + k), hs_coef.size(), base + k + 1);
      end
    end
  endtask

  task automatic run_vec(input logic [PW-1:0] p, input logic [D*N-1:0] c, input bit stall);
    int t;
    clear_q();
    @(negedge clk);
    in_p      = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_acc(1);
    in_valid = 1'b0;
    t = 0;
    while (hs_coef.size() < D && t < 100) begin
      if (stall) out_ready = (t % 4 == 0) || (t % 4 == 3);
      else       out_ready = 1'b1;
      @(negedge clk);
      t++;
    end
    out_ready = 1'b1;
    chk("stream_len", hs_coef.size(), D);
    chk_stream(0, c);
    if (!stall && hs_coef.size() == D && acc_edge.size() == 1) begin
      chk("first_latency", hs_edge[0] - acc_edge[0], 2);
      chk("stream_span", hs_edge[D-1] - hs_edge[0], D - 1);
    end
  endtask

  initial begin
    tbl[0].p = 28'h0011000;  tbl[0].c = 16'h100F;  // (1+x)*x^3: 15,0,0,1
    tbl[1].p = 28'hFFFFFFF;  tbl[1].c = 16'hF000;  // all 15: wrap to 0,0,0,15
    tbl[2].p = 28'h7654321;  tbl[2].c = 16'h4CCC;  // 1-5,2-6,3-7 -> 12; c3=4
    tbl[3].p = 28'h1F23907;  tbl[3].c = 16'h3815;  // 7-2=5, 0-15=1, 9-1=8, 3

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_p      = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_coef", int'(out_coef), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_vec(tbl[v].p, tbl[v].c, 1'b0);
    end

    // Backpressure: out_ready pattern 1,0,0,1; stream must match the no-stall result.
    run_vec(tbl[2].p, tbl[2].c, 1'b1);
    run_vec(tbl[3].p, tbl[3].c, 1'b1);

    // Back-to-back: in_valid held high, second product switched in after the first accept.
    clear_q();
    @(negedge clk);
    in_p      = tbl[0].p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_acc(1);
    in_p = tbl[3].p;
    wait_acc(2);
    in_valid = 1'b0;
    wait_hs(2 * D);
    if (acc_edge.size() >= 2) chk("accept_period", acc_edge[1] - acc_edge[0], D + 2);
    chk_stream(0, tbl[0].c);
    chk_stream(D, tbl[3].c);

    // Reset mid-EMIT after two coefficients.
    clear_q();
    @(negedge clk);
    in_p      = tbl[2].p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_acc(1);
    in_valid = 1'b0;
    wait_hs(2);
    out_ready = 1'b0;
    chk("pre_reset_valid", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_in_ready", int'(in_ready), 1);
    chk("async_out_idx", int'(out_idx), 0);
    chk("async_out_last", int'(out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(tbl[1].p, tbl[1].c, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
